// File: rtl/memlcd_panel_rx.sv
// memlcd_panel_rx: panel-side receiver for the memory-LCD interface.
// Rebuilds the raster as (x, y, data) pixel writes and flags protocol errors.
module memlcd_panel_rx #(
    parameter int PIX_PER_LINE = 120,
    parameter int LINES        = 640,
    parameter int RGB_WIDTH    = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_gsp,
    input  logic                 i_gck,
    input  logic                 i_bsp,
    input  logic                 i_bck,
    input  logic [RGB_WIDTH-1:0] i_rgb,
    output logic                 o_wr_en,
    output logic [6:0]           o_wr_x,
    output logic [9:0]           o_wr_y,
    output logic [RGB_WIDTH-1:0] o_wr_data,
    output logic                 o_line_done,
    output logic                 o_frame_done,
    output logic                 o_err_short,
    output logic                 o_err_gck,
    output logic                 o_err_frame
);
    localparam logic [6:0] X_MAX = 7'(PIX_PER_LINE - 1);
    localparam logic [9:0] Y_MAX = 10'(LINES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ARM, S_CAP, S_END} state_t;

    state_t                 r_state, w_nxt;
    logic [3:0]             w_in, r_s, r_p, r_e;
    logic [RGB_WIDTH-1:0]   r_rgb_s, r_rgb_e;
    logic [6:0]             r_x, w_x;
    logic [9:0]             r_y, w_y;
    logic                   r_seen, w_seen;
    logic                   w_gsp, w_gck, w_bsp, w_bck;
    logic                   w_wr, w_ld, w_fd, w_es, w_eg, w_ef;

    assign w_in = {i_gsp, i_gck, i_bsp, i_bck};
    assign {w_gsp, w_gck, w_bsp, w_bck} = r_e;

    // Reset loads the live input levels so leaving reset never looks like an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s     <= w_in;
            r_p     <= w_in;
            r_e     <= '0;
            r_rgb_s <= '0;
            r_rgb_e <= '0;
        end else begin
            r_s     <= w_in;
            r_p     <= r_s;
            r_e     <= {r_s[3] & ~r_p[3], r_s[2] ^ r_p[2], r_s[1] & ~r_p[1], r_s[0] ^ r_p[0]};
            r_rgb_s <= i_rgb;
            r_rgb_e <= r_rgb_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_nxt;
    end

    // A BSP rise wins over a same-cycle BCK edge, which then serves as the ARM dummy.
    always_comb begin
        w_nxt = r_state;
        if (r_state != S_IDLE && w_gsp) w_nxt = S_WAIT;
        else case (r_state)
            S_IDLE:       w_nxt = w_gsp ? S_WAIT : S_IDLE;
            S_WAIT:       w_nxt = w_bsp ? (w_bck ? S_CAP : S_ARM) : S_WAIT;
            S_ARM, S_CAP: w_nxt = w_bsp ? (w_bck ? S_CAP : S_ARM)
                                : (w_bck && r_state == S_ARM) ? S_CAP
                                : (w_bck && r_x == X_MAX) ? S_END : r_state;
            S_END:        w_nxt = (r_y == Y_MAX) ? S_IDLE : S_WAIT;
            default:      w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_x    = r_x;
        w_y    = r_y;
        w_seen = r_seen | w_gck;
        w_wr   = 1'b0;
        w_ld   = 1'b0;
        w_fd   = 1'b0;
        w_es   = 1'b0;
        w_eg   = 1'b0;
        w_ef   = 1'b0;
        if (r_state != S_IDLE && w_gsp) begin
            w_ef   = 1'b1;
            w_es   = (r_state == S_CAP) && (r_x != '0);
            w_x    = '0;
            w_y    = '0;
            w_seen = 1'b0;
        end else case (r_state)
            S_IDLE: begin
                w_seen = 1'b0;
                w_x    = w_gsp ? '0 : r_x;
                w_y    = w_gsp ? '0 : r_y;
            end
            S_WAIT: if (w_bsp) begin
                w_eg   = ~(r_seen | w_gck);
                w_seen = 1'b0;
                w_x    = '0;
            end
            S_ARM, S_CAP: if (w_bsp) begin
                w_es   = 1'b1;
                w_ld   = 1'b1;
                w_y    = (r_y == Y_MAX) ? r_y : r_y + 10'd1;
                w_eg   = ~(r_seen | w_gck);
                w_seen = 1'b0;
                w_x    = '0;
            end else if (w_bck && r_state == S_CAP) begin
                w_wr = 1'b1;
                w_ld = (r_x == X_MAX);
                w_fd = (r_x == X_MAX) && (r_y == Y_MAX);
                w_x  = (r_x == X_MAX) ? r_x : r_x + 7'd1;
            end
            S_END: begin
                w_seen = w_gck;
                w_y    = (r_y == Y_MAX) ? '0 : r_y + 10'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_seen       <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_x       <= '0;
            o_wr_y       <= '0;
            o_wr_data    <= '0;
            o_line_done  <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_short  <= 1'b0;
            o_err_gck    <= 1'b0;
            o_err_frame  <= 1'b0;
        end else begin
            r_x          <= w_x;
            r_y          <= w_y;
            r_seen       <= w_seen;
            o_wr_en      <= w_wr;
            o_wr_x       <= w_wr ? r_x : o_wr_x;
            o_wr_y       <= w_wr ? r_y : o_wr_y;
            o_wr_data    <= w_wr ? r_rgb_e : o_wr_data;
            o_line_done  <= w_ld;
            o_frame_done <= w_fd;
            o_err_short  <= w_es;
            o_err_gck    <= w_eg;
            o_err_frame  <= w_ef;
        end
    end
endmodule
